// File: rtl/md_phv_discard_pkg.sv
// rtl/md_phv_discard_pkg.sv - shared widths, MD field offsets, config opcodes/addresses, FSM states
package md_phv_discard_pkg;

  localparam int MD_W  = 256;
  localparam int PHV_W = 1024;
  localparam int CFG_W = 134;

  // MD field offsets
  localparam int MID_HI      = 87;
  localparam int MID_LO      = 80;
  localparam int DISCARD_BIT = 108;
  localparam int LEN_HI      = 107;
  localparam int LEN_LO      = 96;

  // Config word field offsets
  localparam int CFG_OP_HI   = 126;
  localparam int CFG_OP_LO   = 124;
  localparam int CFG_ADDR_HI = 95;
  localparam int CFG_ADDR_LO = 64;

  // Config opcodes
  localparam logic [2:0] CFG_WR   = 3'b010;
  localparam logic [2:0] CFG_RD   = 3'b001;
  localparam logic [2:0] CFG_RESP = 3'b011;

  // Config register addresses
  localparam logic [31:0] ADDR_CLR       = 32'h7000_0010;
  localparam logic [31:0] ADDR_DROP_EN   = 32'h7000_0011;
  localparam logic [31:0] ADDR_FWD_PKT   = 32'h7000_0012;
  localparam logic [31:0] ADDR_DROP_PKT  = 32'h7000_0013;
  localparam logic [31:0] ADDR_DROP_BYTE = 32'h7000_0014;
  localparam logic [31:0] ADDR_OVF       = 32'h7000_0015;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/md_phv_discard_if.sv
// rtl/md_phv_discard_if.sv - paired MD/PHV bus with write strobes and almost-full backpressure
// Signals:
//   md/md_wr     metadata word and write strobe (master -> slave)
//   phv/phv_wr   PHV word and write strobe (master -> slave)
//   md_alf       metadata almost-full (slave -> master)
//   phv_alf      PHV almost-full (slave -> master)
interface md_phv_discard_if
  import md_phv_discard_pkg::*;
  ;

  logic [MD_W-1:0]  md;
  logic             md_wr;
  logic             md_alf;
  logic [PHV_W-1:0] phv;
  logic             phv_wr;
  logic             phv_alf;

  modport master (
    output md, md_wr, phv, phv_wr,
    input  md_alf, phv_alf
  );

  modport slave (
    input  md, md_wr, phv, phv_wr,
    output md_alf, phv_alf
  );

endinterface

// File: rtl/md_phv_discard_sync_fifo_sa.sv
// rtl/md_phv_discard_sync_fifo_sa.sv - synchronous show-ahead FIFO with fill level
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr, wdata    write strobe and data; writes while full are ignored
//   rd           pop strobe; ignored while empty
//   rdata        head entry, valid whenever empty is low
//   usedw        number of stored entries (0..2**AW)
//   full, empty  status flags
module md_phv_discard_sync_fifo_sa #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      usedw,
  output logic             full,
  output logic             empty
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_U = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (usedw == DEPTH_U);
  assign empty = (usedw == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  // Show-ahead: the head entry is presented without waiting for a pop.
  assign rdata = mem[rptr];

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      usedw <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (do_rd) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   usedw <= usedw + 1'b1;
        2'b01:   usedw <= usedw - 1'b1;
        default: usedw <= usedw;
      endcase
    end
  end

endmodule

// File: rtl/md_phv_discard.sv
// rtl/md_phv_discard.sv - buffers MD/PHV pairs, drops discard-flagged pairs owned by LMID, counts via config chain
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   up (slave)     from statistics stage: md/md_wr, phv/phv_wr in; md_alf/phv_alf out
//   dn (master)    to next module: md/md_wr, phv/phv_wr out; md_alf/phv_alf in
//   cin_data/_wr   config word in, valid
//   cout_data/_wr  config word out (1-cycle registered), valid
//   cin_ready      config ready from downstream; cout_ready mirrors it upstream
module md_phv_discard
  import md_phv_discard_pkg::*;
#(
  parameter logic [7:0] LMID       = 8'd5,
  parameter logic [7:0] NMID       = 8'd6,
  parameter int         FIFO_AW    = 4,
  parameter int         ALF_MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  md_phv_discard_if.slave  up,
  md_phv_discard_if.master dn,
  input  logic [CFG_W-1:0] cin_data,
  input  logic             cin_data_wr,
  output logic             cout_ready,
  output logic [CFG_W-1:0] cout_data,
  output logic             cout_data_wr,
  input  logic             cin_ready
);

  localparam logic [FIFO_AW:0] ALF_LEVEL = (FIFO_AW + 1)'((1 << FIFO_AW) - ALF_MARGIN);

  // FIFO side
  logic [MD_W-1:0]  md_head;
  logic [PHV_W-1:0] phv_head;
  logic [FIFO_AW:0] md_usedw;
  logic [FIFO_AW:0] phv_usedw;
  logic             md_full;
  logic             phv_full;
  logic             md_empty;
  logic             phv_empty;
  logic             fifo_rd;

  // Pipeline state
  state_t           state;
  logic [MD_W-1:0]  out_md_q;
  logic [PHV_W-1:0] out_phv_q;
  logic             out_wr_q;

  // Decision on the FIFO head
  logic             head_is_lmid;
  logic             head_drop;
  logic [MD_W-1:0]  md_fwd;

  // Counters and control
  logic [31:0]      fwd_pkt_cnt;
  logic [31:0]      drop_pkt_cnt;
  logic [31:0]      drop_byte_cnt;
  logic [31:0]      ovf_cnt;
  logic             drop_en;
  logic             ovf_evt;

  // Config decode
  logic [2:0]       cfg_op;
  logic [31:0]      cfg_addr;
  logic             cfg_is_wr;
  logic             cfg_clr;
  logic             cfg_drop_en_wr;
  logic [CFG_W-1:0] cfg_next;

  md_phv_discard_sync_fifo_sa #(.WIDTH(MD_W), .AW(FIFO_AW)) u_md_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (up.md_wr),
    .wdata (up.md),
    .rd    (fifo_rd),
    .rdata (md_head),
    .usedw (md_usedw),
    .full  (md_full),
    .empty (md_empty)
  );

  md_phv_discard_sync_fifo_sa #(.WIDTH(PHV_W), .AW(FIFO_AW)) u_phv_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (up.phv_wr),
    .wdata (up.phv),
    .rd    (fifo_rd),
    .rdata (phv_head),
    .usedw (phv_usedw),
    .full  (phv_full),
    .empty (phv_empty)
  );

  // Downstream backpressure is folded into our own almost-full so upstream
  // stalls early while the pipeline is blocked.
  assign up.md_alf  = (md_usedw >= ALF_LEVEL) | dn.md_alf;
  assign up.phv_alf = (phv_usedw >= ALF_LEVEL) | dn.phv_alf;

  // Both FIFOs are known non-empty on entry to EVAL, so one pop each is safe.
  assign fifo_rd = (state == ST_EVAL);

  assign head_is_lmid = (md_head[MID_HI:MID_LO] == LMID);
  assign head_drop    = drop_en && md_head[DISCARD_BIT] && head_is_lmid;

  always_comb begin
    md_fwd = md_head;
    if (head_is_lmid) begin
      md_fwd[MID_HI:MID_LO] = NMID;
    end
  end

  assign dn.md   = out_md_q;
  assign dn.phv  = out_phv_q;
  assign dn.md_wr  = out_wr_q;
  assign dn.phv_wr = out_wr_q;

  // Pair pipeline. Downstream almost-full is only sampled in IDLE, so a pair
  // already in EVAL/OUT always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_md_q  <= '0;
      out_phv_q <= '0;
      out_wr_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_wr_q <= 1'b0;
          if (!md_empty && !phv_empty && !dn.md_alf && !dn.phv_alf) begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (head_drop) begin
            state <= ST_IDLE;
          end else begin
            out_md_q  <= md_fwd;
            out_phv_q <= phv_head;
            out_wr_q  <= 1'b1;
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          out_wr_q <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          out_wr_q <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // A pair write hitting a full FIFO counts once even if both halves overflow.
  assign ovf_evt = (up.md_wr && md_full) || (up.phv_wr && phv_full);

  assign cfg_op         = cin_data[CFG_OP_HI:CFG_OP_LO];
  assign cfg_addr       = cin_data[CFG_ADDR_HI:CFG_ADDR_LO];
  assign cfg_is_wr      = cin_data_wr && (cfg_op == CFG_WR);
  assign cfg_clr        = cfg_is_wr && (cfg_addr == ADDR_CLR) && cin_data[0];
  assign cfg_drop_en_wr = cfg_is_wr && (cfg_addr == ADDR_DROP_EN);

  // Reads of our counters are turned into responses in the forwarded word.
  always_comb begin
    cfg_next = cin_data;
    if (cin_data_wr && (cfg_op == CFG_RD)) begin
      case (cfg_addr)
        ADDR_FWD_PKT: begin
          cfg_next[CFG_OP_HI:CFG_OP_LO] = CFG_RESP;
          cfg_next[31:0]                = fwd_pkt_cnt;
        end
        ADDR_DROP_PKT: begin
          cfg_next[CFG_OP_HI:CFG_OP_LO] = CFG_RESP;
          cfg_next[31:0]                = drop_pkt_cnt;
        end
        ADDR_DROP_BYTE: begin
          cfg_next[CFG_OP_HI:CFG_OP_LO] = CFG_RESP;
          cfg_next[31:0]                = drop_byte_cnt;
        end
        ADDR_OVF: begin
          cfg_next[CFG_OP_HI:CFG_OP_LO] = CFG_RESP;
          cfg_next[31:0]                = ovf_cnt;
        end
        default: cfg_next = cin_data;
      endcase
    end
  end

  assign cout_ready = cin_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_data     <= '0;
      cout_data_wr  <= 1'b0;
      fwd_pkt_cnt   <= '0;
      drop_pkt_cnt  <= '0;
      drop_byte_cnt <= '0;
      ovf_cnt       <= '0;
      drop_en       <= 1'b1;
    end else begin
      cout_data    <= cfg_next;
      cout_data_wr <= cin_data_wr;
      // Clear takes priority; an increment in the same cycle is lost.
      if (cfg_clr) begin
        fwd_pkt_cnt   <= '0;
        drop_pkt_cnt  <= '0;
        drop_byte_cnt <= '0;
        ovf_cnt       <= '0;
      end else begin
        if (state == ST_OUT) begin
          fwd_pkt_cnt <= fwd_pkt_cnt + 32'd1;
        end
        if ((state == ST_EVAL) && head_drop) begin
          drop_pkt_cnt  <= drop_pkt_cnt + 32'd1;
          drop_byte_cnt <= drop_byte_cnt + {20'b0, md_head[LEN_HI:LEN_LO]};
        end
        if (ovf_evt) begin
          ovf_cnt <= sat_inc(ovf_cnt);
        end
      end
      if (cfg_drop_en_wr) begin
        drop_en <= cin_data[0];
      end
    end
  end

endmodule

// File: doc/md_phv_discard.md
Name: md_phv_discard

Overview:
- Stage directly downstream of the statistics stage in the MD/PHV pipeline.
- Buffers paired MD (256b) and PHV (1024b) words and acts on the MD discard flag (md[108]).
- When the MD target module ID matches LMID, flagged pairs are dropped and counted; all other pairs are forwarded to the next module.
- Forwarded/dropped counters are exposed through the 134-bit configuration packet chain.

Parameters:
LMID, 8'd5, module ID this stage owns; drop is applied only when md[87:80]==LMID
NMID, 8'd6, ID written into md[87:80] of forwarded pairs whose md[87:80]==LMID
FIFO_AW, 4, address width of each MD/PHV FIFO (depth 2**FIFO_AW = 16)
ALF_MARGIN, 4, almost-full asserted when usedw >= depth-ALF_MARGIN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_md  in  256  metadata from upstream stage
in_md_wr  in  1  metadata write strobe
out_md_alf  out  1  metadata almost-full to upstream
in_phv  in  1024  PHV from upstream stage
in_phv_wr  in  1  PHV write strobe
out_phv_alf  out  1  PHV almost-full to upstream
out_md  out  256  metadata to next module
out_md_wr  out  1  metadata write strobe
in_md_alf  in  1  next module metadata almost-full
out_phv  out  1024  PHV to next module
out_phv_wr  out  1  PHV write strobe
in_phv_alf  in  1  next module PHV almost-full
cin_data  in  134  config packet word in
cin_data_wr  in  1  config word valid
cout_ready  out  1  config ready to upstream, equal to cin_ready
cout_data  out  134  config packet word out
cout_data_wr  out  1  config word valid out
cin_ready  in  1  config ready from downstream

Behaviour:
- Reset: clk, rst_n (asynchronous, active-low). All outputs 0. Counters 0. drop_en=1. FIFOs empty.
- Input buffering:
  - Two show-ahead FIFOs: MD and PHV, written independently.
  - A write to a full FIFO is discarded and increments ovf_cnt (saturating at 32'hFFFFFFFF).
  - out_md_alf = (md_usedw >= depth-ALF_MARGIN) | in_md_alf.
  - out_phv_alf = (phv_usedw >= depth-ALF_MARGIN) | in_phv_alf.
- FSM states: IDLE, EVAL, OUT.
  - IDLE: when both FIFOs are non-empty and !in_md_alf && !in_phv_alf, go to EVAL.
  - EVAL: pop both FIFOs this cycle (rd pulse of exactly 1 cycle).
    - Drop when drop_en && md[108] && md[87:80]==LMID: increment drop_pkt_cnt, add {20'b0,md[107:96]} to drop_byte_cnt (32b wrap), return to IDLE.
    - Otherwise register out_md (md[87:80] replaced by NMID if it equals LMID; all other bits unchanged) and out_phv, then go to OUT.
  - OUT: out_md_wr=out_phv_wr=1 for exactly this cycle; increment fwd_pkt_cnt; go to IDLE.
  - Latency: 3 cycles from FIFO non-empty to output strobe. Maximum throughput: one pair per 3 cycles.
- Downstream alf rising during EVAL or OUT does not abort the in-flight pair.
- Config chain:
  - cout_data/cout_data_wr are a 1-cycle registered copy of cin_data/cin_data_wr, with the modifications below.
  - Write (cin_data[126:124]==3'b010, addr = [95:64], data = [31:0]):
    - 70000010: bit0=1 clears all four counters next cycle. A counter increment in the same cycle is lost; clear wins.
    - 70000011: drop_en = bit0.
  - Read (cin_data[126:124]==3'b001): forwarded word has [126:124]=3'b011 and [31:0] replaced by the counter:
    - 70000012 fwd_pkt_cnt
    - 70000013 drop_pkt_cnt
    - 70000014 drop_byte_cnt
    - 70000015 ovf_cnt
  - Other addresses are passed through unchanged.
- Reset mid-operation: the in-flight pair and FIFO contents are lost. No output strobe is produced after reset.

Decomposition:
- Shared package:
  - MD field offsets: MID_HI=87, MID_LO=80, DISCARD_BIT=108, LEN_HI=107, LEN_LO=96.
  - Config opcodes: CFG_WR=3'b010, CFG_RD=3'b001, CFG_RESP=3'b011.
  - Config addresses 70000010..70000015.
  - FSM state encoding.
- One sub-module: sync_fifo_sa (parameterized width/depth, show-ahead, usedw/full/empty), instantiated for MD and PHV.

Test Plan:
- Single pair with md[87:80]=5, md[108]=0 -> 3 cycles later out_md_wr=out_phv_wr=1 for 1 cycle, out_md[87:80]=6, PHV identical; read 70000012 returns 1.
- Pair with md[87:80]=5, md[108]=1, md[107:96]=12'd1500 -> no output strobe; read 70000013=1, 70000014=1500.
- Same flagged pair with md[87:80]=9 -> forwarded unchanged with ID 9; drop counters remain 0.
- Write 70000011=0, then send a flagged LMID pair -> forwarded with ID 6; write 70000010=1 -> all reads return 0.
- Hold in_md_alf=1, push 13 pairs -> no output; out_md_alf=1 at usedw 12. Push 4 more -> ovf_cnt=1 (17th write dropped). Release -> exactly 16 pairs out in order.
- Assert rst_n=0 during OUT -> out_md_wr=0 immediately; FIFOs empty; counters 0 after release.
